// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields plus a signed immediate into an R/I/S/B/U/J word,
// flags out-of-range or misaligned immediates, and streams through a two-stage valid/ready pipeline.
module instr_encoder #(
  parameter int ERR_COUNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_fmt,
  input  logic [6:0]             in_opcode,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic [31:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic                   out_err,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic [31:0] enc_instr;

  logic        s1_valid;
  logic [31:0] s1_instr;
  logic        s1_err;
  logic        s2_valid;
  logic        s2_load;
  logic        s1_load;

  // An immediate fits when every bit above the field's sign bit matches it
  always_comb begin
    enc_legal = 1'b0;
    enc_word  = NOP_WORD;
    case (in_fmt)
      FMT_R: begin
        enc_legal = 1'b1;
        enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        enc_legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        enc_legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        enc_legal = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      end
      FMT_U: begin
        enc_legal = ~(|in_imm[11:0]);
        enc_word  = {in_imm[31:12], in_rd, in_opcode};
      end
      FMT_J: begin
        enc_legal = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: begin
        enc_legal = 1'b0;
        enc_word  = NOP_WORD;
      end
    endcase
  end

  // Illegal words collapse to a NOP so no partial encoding ever leaves the block
  assign enc_instr = enc_legal ? enc_word : NOP_WORD;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_instr <= 32'h0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_instr <= enc_instr;
        s1_err   <= !enc_legal;
      end
    end
  end

  // S2 only overwrites its word when it is empty or the current word is being taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_instr <= 32'h0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= s1_instr;
        out_err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != {ERR_COUNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, error words, backpressure,
// error-counter saturation and mid-stream reset, with an in-order output scoreboard.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          accepted = 0;
  int          delivered = 0;
  int          a0;
  int          d0;
  logic [31:0] bp_table [6];

  always #5 clk = ~clk;

  instr_encoder #(.ERR_COUNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, req);
    end
  endtask

  // Holds the word on the inputs until an edge where in_ready was high beforehand
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input logic [31:0] exp_instr, input logic exp_err);
    bit   acc;
    int   n;
    exp_t e;
    in_fmt    = fmt;
    in_opcode = opc;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) begin
      e.instr = exp_instr;
      e.err   = exp_err;
      exp_q.push_back(e);
      accepted++;
    end else begin
      checkOutput("accept timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) checkOutput("drain timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Every output transfer about to happen at the next rising edge is matched in order
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious output", out_instr, 32'hdead_beef);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_instr", out_instr, mon_e.instr);
        checkOutput("out_err", {31'b0, out_err}, {31'b0, mon_e.err});
      end
      delivered++;
    end
  end

  initial begin
    bp_table = '{32'h0010_0093, 32'h0020_0093, 32'h0030_0093,
                 32'h0040_0093, 32'h0050_0093, 32'h0060_0093};
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0;
    in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
    #12;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset out_instr", out_instr, 32'd0);
    checkOutput("reset out_err", {31'b0, out_err}, 32'd0);
    checkOutput("reset err_count", {24'b0, err_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_ready after reset", {31'b0, in_ready}, 32'd1);

    out_ready = 1'b1;
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    checkOutput("latency early", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("latency valid", {31'b0, out_valid}, 32'd1);
    checkOutput("addi -1 word", out_instr, 32'hFFF0_0093);

    applyStimulus(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    applyStimulus(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    applyStimulus(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    applyStimulus(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFE11_2C23, 1'b0);
    applyStimulus(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'hABCD_0000, 32'h4020_81B3, 1'b0);
    waitDrain();
    checkOutput("err_count legal", {24'b0, err_count}, 32'd0);

    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
    applyStimulus(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 1'b1);
    applyStimulus(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
    applyStimulus(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    waitDrain();
    checkOutput("err_count four", {24'b0, err_count}, 32'd4);

    out_ready = 1'b0;
    a0 = accepted;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1), bp_table[i], 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        checkOutput("bp accepted", 32'(accepted - a0), 32'd2);
        checkOutput("bp in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("bp hold instr", out_instr, 32'h0010_0093);
        d0 = delivered;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        checkOutput("bp no gaps", 32'(delivered - d0), 32'd6);
      end
    join
    waitDrain();

    out_ready = 1'b0;
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0093, 1'b0);
    applyStimulus(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0000_0013, 1'b1);
    checkOutput("full in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midreset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset err_count", {24'b0, err_count}, 32'd0);
    checkOutput("midreset out_instr", out_instr, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("post reset out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    d0 = delivered;
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0093, 1'b0);
    waitDrain();
    checkOutput("post reset delivered", 32'(delivered - d0), 32'd1);

    for (int i = 0; i < 260; i++)
      applyStimulus(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    waitDrain();
    checkOutput("err_count saturated", {24'b0, err_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
